// File: rtl/fighting_game_arena.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | fighting_game_arena                                                |
// | Two-player fighting core: positions, health, cooldown, match FSM.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fighting_game_arena #(
    parameter int ARENA_W       = 8,
    parameter int LOC_W         = 3,
    parameter int HEALTH_MAX    = 7,
    parameter int HP_W          = 3,
    parameter int COOLDOWN      = 3,
    parameter int ROUNDS_TO_WIN = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       right_player_input,
    input  logic [5:0]       left_player_input,
    output logic [LOC_W-1:0] right_player_location_out,
    output logic [HP_W-1:0]  right_player_health_out,
    output logic [LOC_W-1:0] left_player_location_out,
    output logic [HP_W-1:0]  left_player_health_out,
    output logic [1:0]       round_state,
    output logic [1:0]       round_winner,
    output logic [1:0]       left_wins,
    output logic [1:0]       right_wins
);
    localparam int CD_W = $clog2(COOLDOWN + 1);

    localparam logic [1:0]       c_IDLE       = 2'd0;
    localparam logic [1:0]       c_FIGHT      = 2'd1;
    localparam logic [1:0]       c_KO         = 2'd2;
    localparam logic [1:0]       c_MATCH      = 2'd3;
    localparam logic [LOC_W-1:0] c_RIGHT_HOME = LOC_W'(ARENA_W - 1);
    localparam logic [HP_W-1:0]  c_HP_FULL    = HP_W'(HEALTH_MAX);
    localparam logic [CD_W-1:0]  c_CD_LOAD    = CD_W'(COOLDOWN);
    localparam logic [1:0]       c_WINS_NEED  = 2'(ROUNDS_TO_WIN);

    logic [1:0]       r_state, w_state_nxt;
    logic [LOC_W-1:0] r_lloc, r_rloc, w_lloc_nxt, w_rloc_nxt, w_dist;
    logic [HP_W-1:0]  r_lhp, r_rhp, w_lhp_nxt, w_rhp_nxt;
    logic [CD_W-1:0]  r_lcd, r_rcd, w_lcd_nxt, w_rcd_nxt;
    logic [1:0]       r_winner, r_lwins, r_rwins, r_ko_cnt;
    logic [1:0]       w_dmg_to_l, w_dmg_to_r;
    logic             w_fight, w_ko_exit, w_match_done, w_ko;
    logic             w_l_ready, w_r_ready, w_l_kick, w_l_punch, w_r_kick, w_r_punch;
    logic             w_l_move, w_r_move, w_l_in, w_l_out, w_r_in, w_r_out;

    assign w_match_done = (r_lwins >= c_WINS_NEED) || (r_rwins >= c_WINS_NEED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (left_player_input[5] || right_player_input[5]) w_state_nxt = c_FIGHT;
            c_FIGHT: if (w_ko) w_state_nxt = c_KO;
            c_KO:    if (w_ko_exit) w_state_nxt = w_match_done ? c_MATCH : c_IDLE;
            default: w_state_nxt = r_state;
        endcase
    end

    always_comb begin
        w_fight     = (r_state == c_FIGHT);
        w_ko_exit   = (r_state == c_KO) && (r_ko_cnt == 2'd3);
        round_state = r_state;
    end

    // Both attacks resolve against the distance at the start of the cycle.
    always_comb begin
        w_dist    = r_rloc - r_lloc;
        w_l_ready = w_fight && (r_lcd == '0);
        w_r_ready = w_fight && (r_rcd == '0);
        w_l_kick  = w_l_ready && left_player_input[3];
        w_l_punch = w_l_ready && !left_player_input[3] && left_player_input[2];
        w_r_kick  = w_r_ready && right_player_input[3];
        w_r_punch = w_r_ready && !right_player_input[3] && right_player_input[2];
        w_l_move  = w_l_ready && !left_player_input[3] && !left_player_input[2]
                    && (left_player_input[0] ^ left_player_input[1]);
        w_r_move  = w_r_ready && !right_player_input[3] && !right_player_input[2]
                    && (right_player_input[0] ^ right_player_input[1]);
        w_l_in    = w_l_move && left_player_input[1];
        w_l_out   = w_l_move && left_player_input[0];
        w_r_in    = w_r_move && right_player_input[0];
        w_r_out   = w_r_move && right_player_input[1];

        w_dmg_to_r = 2'd0;
        if (w_l_kick && (w_dist <= LOC_W'(2)))
            w_dmg_to_r = right_player_input[4] ? 2'd1 : 2'd2;
        else if (w_l_punch && (w_dist <= LOC_W'(1)))
            w_dmg_to_r = right_player_input[4] ? 2'd0 : 2'd1;

        w_dmg_to_l = 2'd0;
        if (w_r_kick && (w_dist <= LOC_W'(2)))
            w_dmg_to_l = left_player_input[4] ? 2'd1 : 2'd2;
        else if (w_r_punch && (w_dist <= LOC_W'(1)))
            w_dmg_to_l = left_player_input[4] ? 2'd0 : 2'd1;

        w_lhp_nxt = (r_lhp <= HP_W'(w_dmg_to_l)) ? '0 : r_lhp - HP_W'(w_dmg_to_l);
        w_rhp_nxt = (r_rhp <= HP_W'(w_dmg_to_r)) ? '0 : r_rhp - HP_W'(w_dmg_to_r);
        w_ko      = (w_lhp_nxt == '0) || (w_rhp_nxt == '0);

        // Inward steps keep left < right; at distance 2 a mutual step cancels both.
        w_lloc_nxt = r_lloc;
        if (w_l_out && (r_lloc != '0))
            w_lloc_nxt = r_lloc - LOC_W'(1);
        else if (w_l_in && ((w_dist > LOC_W'(2)) || ((w_dist == LOC_W'(2)) && !w_r_in)))
            w_lloc_nxt = r_lloc + LOC_W'(1);

        w_rloc_nxt = r_rloc;
        if (w_r_out && (r_rloc != c_RIGHT_HOME))
            w_rloc_nxt = r_rloc + LOC_W'(1);
        else if (w_r_in && ((w_dist > LOC_W'(2)) || ((w_dist == LOC_W'(2)) && !w_l_in)))
            w_rloc_nxt = r_rloc - LOC_W'(1);

        w_lcd_nxt = (w_l_kick || w_l_punch) ? c_CD_LOAD :
                    (r_lcd != '0) ? r_lcd - CD_W'(1) : '0;
        w_rcd_nxt = (w_r_kick || w_r_punch) ? c_CD_LOAD :
                    (r_rcd != '0) ? r_rcd - CD_W'(1) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lloc   <= '0;
            r_rloc   <= c_RIGHT_HOME;
            r_lhp    <= c_HP_FULL;
            r_rhp    <= c_HP_FULL;
            r_lcd    <= '0;
            r_rcd    <= '0;
            r_winner <= 2'b00;
            r_lwins  <= 2'd0;
            r_rwins  <= 2'd0;
            r_ko_cnt <= 2'd0;
        end else begin
            case (r_state)
                c_FIGHT: begin
                    r_lloc <= w_lloc_nxt;
                    r_rloc <= w_rloc_nxt;
                    r_lhp  <= w_lhp_nxt;
                    r_rhp  <= w_rhp_nxt;
                    r_lcd  <= w_lcd_nxt;
                    r_rcd  <= w_rcd_nxt;
                    if (w_ko) begin
                        r_ko_cnt <= 2'd0;
                        if ((w_lhp_nxt == '0) && (w_rhp_nxt == '0)) begin
                            r_winner <= 2'b11;
                        end else if (w_lhp_nxt == '0) begin
                            r_winner <= 2'b10;
                            r_rwins  <= (r_rwins == 2'd3) ? 2'd3 : r_rwins + 2'd1;
                        end else begin
                            r_winner <= 2'b01;
                            r_lwins  <= (r_lwins == 2'd3) ? 2'd3 : r_lwins + 2'd1;
                        end
                    end
                end
                c_KO: begin
                    r_ko_cnt <= r_ko_cnt + 2'd1;
                    if (w_ko_exit) begin
                        if (w_match_done) begin
                            r_winner <= (r_lwins >= c_WINS_NEED) ? 2'b01 : 2'b10;
                        end else begin
                            r_lloc   <= '0;
                            r_rloc   <= c_RIGHT_HOME;
                            r_lhp    <= c_HP_FULL;
                            r_rhp    <= c_HP_FULL;
                            r_lcd    <= '0;
                            r_rcd    <= '0;
                            r_winner <= 2'b00;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign left_player_location_out  = r_lloc;
    assign right_player_location_out = r_rloc;
    assign left_player_health_out    = r_lhp;
    assign right_player_health_out   = r_rhp;
    assign round_winner              = r_winner;
    assign left_wins                 = r_lwins;
    assign right_wins                = r_rwins;

endmodule
`default_nettype wire

// File: tb/tb_fighting_game_arena.sv
`timescale 1ns/1ps
`default_nettype none
// tb_fighting_game_arena: directed scenarios plus random play, checked
// against an integer rules model of the arena.
module tb_fighting_game_arena;
    localparam int W    = 8;
    localparam int HMAX = 7;
    localparam int CD   = 3;
    localparam int RTW  = 2;

    localparam logic [5:0] NONE  = 6'h00;
    localparam logic [5:0] ML    = 6'h01;
    localparam logic [5:0] MR    = 6'h02;
    localparam logic [5:0] PUNCH = 6'h04;
    localparam logic [5:0] KICK  = 6'h08;
    localparam logic [5:0] BLOCK = 6'h10;
    localparam logic [5:0] START = 6'h20;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] li    = '0;
    logic [5:0] ri    = '0;
    logic [2:0] l_loc, r_loc, l_hp, r_hp;
    logic [1:0] st, win, lw, rw;

    int checks   = 0;
    int failures = 0;
    int m_l, m_r, m_lhp, m_rhp, m_lcd, m_rcd, m_st, m_win, m_lw, m_rw, m_ko;

    always #5 clk = ~clk;

    fighting_game_arena dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .right_player_input        (ri),
        .left_player_input         (li),
        .right_player_location_out (r_loc),
        .right_player_health_out   (r_hp),
        .left_player_location_out  (l_loc),
        .left_player_health_out    (l_hp),
        .round_state               (st),
        .round_winner              (win),
        .left_wins                 (lw),
        .right_wins                (rw)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_round_reset();
        m_l = 0; m_r = W - 1; m_lhp = HMAX; m_rhp = HMAX; m_lcd = 0; m_rcd = 0;
    endtask

    task automatic m_reset();
        m_round_reset();
        m_st = 0; m_win = 0; m_lw = 0; m_rw = 0; m_ko = 0;
    endtask

    task automatic m_step(input logic [5:0] a, input logic [5:0] b);
        int d, dl, dr, ml, mr, nl, nr;
        bit la, ra;
        case (m_st)
            0: if (a[5] || b[5]) m_st = 1;
            1: begin
                d  = m_r - m_l;
                la = (m_lcd == 0) && (a[2] || a[3]);
                ra = (m_rcd == 0) && (b[2] || b[3]);
                dl = 0; dr = 0;
                if (m_lcd == 0) begin
                    if (a[3])      dr = (d <= 2) ? (b[4] ? 1 : 2) : 0;
                    else if (a[2]) dr = (d <= 1) ? (b[4] ? 0 : 1) : 0;
                end
                if (m_rcd == 0) begin
                    if (b[3])      dl = (d <= 2) ? (a[4] ? 1 : 2) : 0;
                    else if (b[2]) dl = (d <= 1) ? (a[4] ? 0 : 1) : 0;
                end
                ml = 0; mr = 0;
                if (m_lcd == 0 && !la && (a[0] != a[1])) ml = a[1] ? 1 : -1;
                if (m_rcd == 0 && !ra && (b[0] != b[1])) mr = b[1] ? 1 : -1;
                nl = m_l + ml;
                nr = m_r + mr;
                if (ml == 1 && (d == 1 || (d == 2 && mr == -1))) nl = m_l;
                if (mr == -1 && (d == 1 || (d == 2 && ml == 1))) nr = m_r;
                if (nl < 0) nl = 0;
                if (nr > W - 1) nr = W - 1;
                m_l = nl; m_r = nr;
                m_lcd = la ? CD : ((m_lcd > 0) ? m_lcd - 1 : 0);
                m_rcd = ra ? CD : ((m_rcd > 0) ? m_rcd - 1 : 0);
                m_lhp = (m_lhp - dl < 0) ? 0 : m_lhp - dl;
                m_rhp = (m_rhp - dr < 0) ? 0 : m_rhp - dr;
                if (m_lhp == 0 || m_rhp == 0) begin
                    m_st = 2; m_ko = 0;
                    if (m_lhp == 0 && m_rhp == 0) m_win = 3;
                    else if (m_lhp == 0) begin m_win = 2; m_rw = (m_rw < 3) ? m_rw + 1 : 3; end
                    else begin m_win = 1; m_lw = (m_lw < 3) ? m_lw + 1 : 3; end
                end
            end
            2: begin
                m_ko++;
                if (m_ko == 4) begin
                    if (m_lw >= RTW || m_rw >= RTW) begin
                        m_st = 3; m_win = (m_lw >= RTW) ? 1 : 2;
                    end else begin
                        m_round_reset(); m_st = 0; m_win = 0;
                    end
                end
            end
            default: begin end
        endcase
    endtask

    task automatic check_model();
        chk("lloc", 32'(l_loc), m_l);
        chk("rloc", 32'(r_loc), m_r);
        chk("lhp",  32'(l_hp),  m_lhp);
        chk("rhp",  32'(r_hp),  m_rhp);
        chk("state", 32'(st),   m_st);
        chk("lwins", 32'(lw),   m_lw);
        chk("rwins", 32'(rw),   m_rw);
        if (m_st >= 2) chk("winner", 32'(win), m_win);
    endtask

    task automatic step(input logic [5:0] a, input logic [5:0] b);
        li = a; ri = b;
        @(posedge clk);
        m_step(a, b);
        #1;
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(NONE, NONE);
    endtask

    // Reset is asserted between clock edges and checked before any edge.
    task automatic apply_reset();
        #2;
        rst_n = 1'b0; li = '0; ri = '0;
        m_reset();
        #1;
        check_model();
        chk("rst_winner", 32'(win), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic left_round();
        step(START, NONE);
        for (int i = 0; i < 5; i++) step(MR, NONE);
        for (int k = 0; k < 4; k++) begin
            step(KICK, NONE);
            idle(3);
        end
        idle(1);
    endtask

    function automatic logic [5:0] rnd_in();
        logic [5:0] v;
        v[0] = ($urandom_range(0, 1) == 1);
        v[1] = ($urandom_range(0, 1) == 1);
        v[2] = ($urandom_range(0, 4) == 0);
        v[3] = ($urandom_range(0, 4) == 0);
        v[4] = ($urandom_range(0, 1) == 1);
        v[5] = ($urandom_range(0, 5) == 0);
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        #12;
        check_model();
        chk("rst_winner", 32'(win), 0);
        @(negedge clk);
        rst_n = 1'b1;

        step(START, NONE);
        for (int i = 0; i < 3; i++) step(MR, NONE);
        chk("walk_lloc", 32'(l_loc), 3);
        chk("walk_rloc", 32'(r_loc), 7);
        chk("walk_state", 32'(st), 1);
        step(NONE, MR);
        chk("wall_rloc", 32'(r_loc), 7);
        step(NONE, ML); step(NONE, ML);
        step(MR, ML);
        chk("d2_lloc", 32'(l_loc), 3);
        chk("d2_rloc", 32'(r_loc), 5);
        step(NONE, ML);
        step(MR, NONE);
        chk("d1_lloc", 32'(l_loc), 3);
        step(NONE, ML);
        chk("d1_rloc", 32'(r_loc), 4);

        step(PUNCH, NONE);
        chk("punch_rhp", 32'(r_hp), 6);
        for (int i = 0; i < 3; i++) step(PUNCH, NONE);
        chk("cool_rhp", 32'(r_hp), 6);
        step(KICK, BLOCK);
        chk("blkkick_rhp", 32'(r_hp), 5);
        idle(3);

        step(KICK, KICK); idle(3);
        step(KICK, KICK); idle(3);
        step(NONE, KICK); idle(3);
        chk("pre_lhp", 32'(l_hp), 1);
        chk("pre_rhp", 32'(r_hp), 1);
        step(KICK, KICK);
        chk("draw_winner", 32'(win), 3);
        chk("draw_state", 32'(st), 2);
        chk("draw_lwins", 32'(lw), 0);
        idle(3);
        chk("ko_hold", 32'(st), 2);
        idle(1);
        chk("ko_exit", 32'(st), 0);
        chk("ko_rhp", 32'(r_hp), 7);

        left_round();
        chk("r1_lwins", 32'(lw), 1);
        chk("r1_state", 32'(st), 0);
        left_round();
        chk("match_state", 32'(st), 3);
        chk("match_winner", 32'(win), 1);
        chk("match_lwins", 32'(lw), 2);
        for (int i = 0; i < 20; i++) step(rnd_in(), rnd_in());
        chk("match_hold", 32'(st), 3);

        apply_reset();
        step(START, NONE);
        step(MR, ML); step(MR, ML); step(KICK, NONE);
        apply_reset();
        chk("mid_rst_state", 32'(st), 0);
        chk("mid_rst_lloc", 32'(l_loc), 0);

        for (int i = 0; i < 3000; i++) begin
            if (m_st == 3 && $urandom_range(0, 3) == 0) apply_reset();
            else step(rnd_in(), rnd_in());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
